fanout_fork_ctrl: RTL
=====================

# fanout_fork_ctrl

Eager-fork controller that shares one producer stream across up to NUM_OUT configured consumers in the onyx fabric. Consumers are not required to be ready in the same cycle. A sticky per-lane "accepted" bit records which consumers have already taken the current token. The producer's ready is released only once every participating consumer has accepted. It replaces the purely combinational ready-AND fanout where consumers stall independently.

## Interface
- NUM_OUT, 9, number of consumer lanes.
- DATA_W, 17, token width (16-bit data plus 1 control bit).
- CNT_W, 16, width of status counters.

- clk  in  1  clock.
- flush  in  1  synchronous active-high reset.
- clk_en  in  1  clock enable; all state holds when low.
- cfg_enable  in  NUM_OUT  per-lane output-enable config.
- cfg_select  in  NUM_OUT  per-lane route-select bit, already extracted from the lane's select field by the wrapper.
- in_valid  in  1  producer token valid.
- in_data  in  DATA_W  producer token.
- in_ready  out  1  token fully delivered this cycle.
- out_valid  out  NUM_OUT  per-lane valid.
- out_data  out  DATA_W  broadcast data, equal to in_data.
- out_ready  in  NUM_OUT  per-lane consumer ready.
- token_count  out  CNT_W  tokens fully delivered; wraps.
- drop_count  out  CNT_W  tokens consumed with zero participants; wraps.
- busy  out  1  high in PARTIAL.

## Operation
- Live participant mask: part_live = cfg_enable & cfg_select.
- Effective mask part:
  - IDLE: part = part_live.
  - PARTIAL: part = part_q, a snapshot taken on the IDLE→PARTIAL transition. Live config is ignored until the token completes.
- done[NUM_OUT] register, reset 0.
- Per-lane handshake:
  - out_valid[i] = in_valid & part[i] & ~done[i].
  - fire[i] = out_valid[i] & out_ready[i].
- in_ready = AND over i of (~part[i] | done[i] | out_ready[i]).
- complete = in_valid & in_ready.
- State IDLE:
  - complete → stay IDLE; done stays 0.
  - in_valid & ~in_ready & (fire != 0) → go to PARTIAL; done ← fire; part_q ← part_live.
  - Otherwise → stay IDLE.
- State PARTIAL:
  - complete → go to IDLE; done ← 0.
  - Otherwise done ← done | fire.
- The producer must hold in_valid/in_data stable until in_ready. in_valid dropping in PARTIAL is a protocol error. It is not checked; state is held.
- Counters:
  - token_count increments on complete when part != 0.
  - drop_count increments on complete when part == 0.
  - Both wrap modulo 2^CNT_W.
- busy = (state == PARTIAL).

## Timing
- Zero-cycle valid/ready paths: out_valid, in_ready and out_data are combinational from inputs and current state.
- Each consumer fires exactly once per token, even if it remains ready across multiple cycles.
- Minimum latency: 1 cycle per token when all participants are ready together. No bubble between back-to-back tokens.
- Zero participants: in_ready = 1; the token is consumed in its valid cycle and counted as a drop.
- While flush is high:
  - in_ready = 0 and out_valid = 0 regardless of inputs.
  - On the next edge: state = IDLE, done = 0, part_q = 0, token_count = 0, drop_count = 0, busy = 0.
- Flush mid-token: delivery progress is lost. After flush, the held token is re-offered to all participants, so consumers may see a duplicate. This is intended.
- clk_en low:
  - No state, done or counter update.
  - Combinational outputs still reflect inputs and held state.
  - Fires occurring in that cycle are not recorded; consumers treat this like stall, as in fabric convention.
- Simultaneous events: the last pending lane firing while the other lanes are already done → complete in that cycle; IDLE next cycle.

## Structure
- Shared package fanout_pkg holds:
  - state enum {IDLE, PARTIAL};
  - default NUM_OUT, DATA_W and CNT_W constants.
- One sub-module is natural: fanout_fork_lane, generated NUM_OUT times. It owns done[i], the part_q[i] mux, out_valid[i], fire[i] and the lane's ready term.
- The top level owns:
  - the state register;
  - the in_ready AND-reduce;
  - the counters.

## Test plan
- NUM_OUT=9, lanes 0, 3 and 8 participating, all ready, 4 back-to-back tokens → in_ready high 4 consecutive cycles; token_count = 4; busy never set.
- Lanes 0, 1 and 2 participate; ready arrives on lane 0 at cycle 1, lane 1 at cycle 3, lane 2 at cycle 5, each held high afterward:
  - out_valid[0] low from cycle 2;
  - in_ready high only at cycle 5;
  - exactly one fire per lane; busy cycles 2–5.
- cfg_enable = 0, 3 tokens → in_ready constantly 1, out_valid = 0, drop_count = 3, token_count = 0.
- In PARTIAL with lane 2 pending, clear cfg_enable[2]:
  - in_ready stays low until out_ready[2];
  - the following token excludes lane 2.
- Assert flush in PARTIAL with done = 3'b011:
  - next cycle done = 0 and counters = 0;
  - out_valid re-asserts on lanes 0–2.
- clk_en low while all participants are ready → no counter change and state unchanged; re-enabling completes the token in 1 cycle.

Source files
------------

// File: rtl/fanout_pkg.sv
// Shared types and default sizing for the eager-fork fanout controller.
package fanout_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StPartial
    } fork_state_e;

    localparam int unsigned NUM_OUT_DEF = 9;
    localparam int unsigned DATA_W_DEF  = 17;
    localparam int unsigned CNT_W_DEF   = 16;

endpackage

// File: rtl/fanout_fork_lane.sv
// One consumer lane of the eager fork: sticky accepted bit, participant snapshot,
// per-lane valid/fire and the lane's contribution to the producer ready.
module fanout_fork_lane
    import fanout_pkg::*;
(
    input  logic clk,
    input  logic flush,
    input  logic clk_en,
    input  logic part_live,
    input  logic partial,
    input  logic load,
    input  logic clear,
    input  logic in_valid,
    input  logic out_ready,
    output logic part,
    output logic out_valid,
    output logic fire,
    output logic ready_term
);

    logic done_q, done_d;
    logic part_q, part_d;

    always_comb begin
        // Config is frozen while a token is partially delivered.
        part       = partial ? part_q : part_live;
        out_valid  = in_valid & part & ~done_q & ~flush;
        fire       = out_valid & out_ready;
        ready_term = ~part | done_q | out_ready;
    end

    always_comb begin
        done_d = clear ? 1'b0 : (done_q | fire);
        part_d = load ? part_live : part_q;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            done_q <= 1'b0;
            part_q <= 1'b0;
        end else if (clk_en) begin
            done_q <= done_d;
            part_q <= part_d;
        end
    end

endmodule

// File: rtl/fanout_fork_ctrl.sv
// Eager-fork controller: broadcasts one producer token to all participating lanes
// and releases the producer only once every participant has accepted it.
module fanout_fork_ctrl
    import fanout_pkg::*;
#(
    parameter int unsigned NUM_OUT = NUM_OUT_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               flush,
    input  logic               clk_en,
    input  logic [NUM_OUT-1:0] cfg_enable,
    input  logic [NUM_OUT-1:0] cfg_select,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic [NUM_OUT-1:0] out_valid,
    output logic [DATA_W-1:0]  out_data,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [CNT_W-1:0]   token_count,
    output logic [CNT_W-1:0]   drop_count,
    output logic               busy
);

    fork_state_e state_q, state_d;

    logic [NUM_OUT-1:0] part_live;
    logic [NUM_OUT-1:0] part;
    logic [NUM_OUT-1:0] fire;
    logic [NUM_OUT-1:0] ready_term;
    logic               partial;
    logic               complete;
    logic               go_partial;
    logic [CNT_W-1:0]   token_q, token_d;
    logic [CNT_W-1:0]   drop_q, drop_d;

    assign part_live = cfg_enable & cfg_select;
    assign partial   = (state_q == StPartial);

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_lane
        fanout_fork_lane u_lane (
            .clk        (clk),
            .flush      (flush),
            .clk_en     (clk_en),
            .part_live  (part_live[i]),
            .partial    (partial),
            .load       (go_partial),
            .clear      (complete),
            .in_valid   (in_valid),
            .out_ready  (out_ready[i]),
            .part       (part[i]),
            .out_valid  (out_valid[i]),
            .fire       (fire[i]),
            .ready_term (ready_term[i])
        );
    end

    always_comb begin
        in_ready   = ~flush & (&ready_term);
        complete   = in_valid & in_ready;
        go_partial = ~partial & in_valid & ~in_ready & (|fire);
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            state_q <= StIdle;
            token_q <= '0;
            drop_q  <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            token_q <= token_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (go_partial) state_d = StPartial;
            StPartial: if (complete) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        token_d = token_q;
        drop_d  = drop_q;
        if (complete) begin
            if (|part) token_d = token_q + CNT_W'(1);
            else       drop_d  = drop_q + CNT_W'(1);
        end
    end

    always_comb begin
        busy        = partial;
        out_data    = in_data;
        token_count = token_q;
        drop_count  = drop_q;
    end

endmodule
